// File: rtl/adder64_arb_pkg.sv
// Shared types and constants for the time-shared 64-bit adder arbiter.
// The optional carry-out port is enabled with ADDER64_ARB_CARRY_EN.
package adder64_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } arb_state_e;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 64;

    // Requester-index width, never narrower than one bit.
    function automatic int id_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/adder64_rr_grant.sv
// Combinational round-robin pick: first valid requester at or after ptr,
// searching upward with wrap. Produces a one-hot grant and its index.
import adder64_arb_pkg::*;

module adder64_rr_grant #(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ_DEF)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    // Rotating priority search starting at ptr.
    always_comb begin
        logic           found_s;
        logic [IDW:0]   sum_s;
        logic [IDW-1:0] idx_s;
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        sum_s     = '0;
        idx_s     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s = {1'b0, ptr} + (IDW+1)'(k);
            if (sum_s >= (IDW+1)'(NREQ)) begin
                sum_s = sum_s - (IDW+1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IDW-1:0];
            if (!found_s && req_valid[idx_s]) begin
                found_s      = 1'b1;
                grant[idx_s] = 1'b1;
                grant_idx    = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/adder64_arbiter.sv
// Round-robin time-sharing of one 64-bit adder between NREQ requesters,
// one operation in flight. Define ADDER64_ARB_CARRY_EN to add rsp_carry.
import adder64_arb_pkg::*;

module adder64_arbiter #(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_x,
    input  logic [NREQ*W-1:0]        req_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [W-1:0]             rsp_sum,
`ifdef ADDER64_ARB_CARRY_EN
    output logic                     rsp_carry,
`endif
    output logic [$clog2(NREQ)-1:0]  rsp_id
);

    localparam int IDW = id_width(NREQ);

    arb_state_e      state_r, state_nxt_s;
    logic [IDW-1:0]  ptr_r, ptr_nxt_s;
    logic [NREQ-1:0] grant_s, req_ready_s;
    logic [IDW-1:0]  grant_idx_s, id_r, rsp_id_r;
    logic            accept_s, rsp_valid_r;
    logic [W-1:0]    x_r, y_r, sum_r;
    logic [W-1:0]    x_arr_s [NREQ];
    logic [W-1:0]    y_arr_s [NREQ];

`ifdef ADDER64_ARB_CARRY_EN
    logic [W:0]      add_s;
    logic            carry_r;
    assign add_s     = {1'b0, x_r} + {1'b0, y_r};
    assign rsp_carry = carry_r;
`else
    logic [W-1:0]    add_s;
    assign add_s     = x_r + y_r;
`endif

    adder64_rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_grant (
        .req_valid (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Unpack the flat operand buses so the winner can be selected by index.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            x_arr_s[i] = req_x[i*W +: W];
            y_arr_s[i] = req_y[i*W +: W];
        end
    end

    // Next-state, accept strobe and per-requester ready.
    always_comb begin
        state_nxt_s = state_r;
        req_ready_s = '0;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready_s = grant_s;
                if (|(req_valid & grant_s)) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ADD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADD: begin
                state_nxt_s = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Pointer moves just past the winner so every requester gets a turn.
    always_comb begin
        if (grant_idx_s == IDW'(NREQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = grant_idx_s + IDW'(1);
        end
    end

    // Ready must stay low for the whole time reset is asserted.
    assign req_ready = req_ready_s & {NREQ{rst_n}};
    assign rsp_valid = rsp_valid_r;
    assign rsp_sum   = sum_r;
    assign rsp_id    = rsp_id_r;

    // FSM state and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                ptr_r <= ptr_nxt_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    // Operand capture on the request handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r  <= '0;
            y_r  <= '0;
            id_r <= '0;
        end else if (accept_s) begin
            x_r  <= x_arr_s[grant_idx_s];
            y_r  <= y_arr_s[grant_idx_s];
            id_r <= grant_idx_s;
        end else begin
            x_r  <= x_r;
            y_r  <= y_r;
            id_r <= id_r;
        end
    end

    // Response registers: the ripple add lands here at the end of ADD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r       <= '0;
            rsp_id_r    <= '0;
            rsp_valid_r <= 1'b0;
`ifdef ADDER64_ARB_CARRY_EN
            carry_r     <= 1'b0;
`endif
        end else if (state_r == ADD) begin
            sum_r       <= add_s[W-1:0];
            rsp_id_r    <= id_r;
            rsp_valid_r <= 1'b1;
`ifdef ADDER64_ARB_CARRY_EN
            carry_r     <= add_s[W];
`endif
        end else if ((state_r == HOLD) && rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

endmodule
